// File: rtl/moesif_bus_pkg.sv
// moesif_bus_pkg: shared command, state and arbitration definitions for the MOESIF bus controller
package moesif_bus_pkg;

    typedef enum logic [1:0] {
        CMD_READ           = 2'd0,
        CMD_READ_EXCLUSIVE = 2'd1,
        CMD_INVALIDATE     = 2'd2,
        CMD_WRITEBACK      = 2'd3
    } busCommandType;

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        INTERVENE,
        RAM_READ,
        RAM_WRITE,
        COMPLETE
    } busStateType;

    localparam int ARB_ROUND_ROBIN    = 0;
    localparam int ARB_FIXED_PRIORITY = 1;

endpackage

// File: rtl/moesif_coherence_bus_controller_arbiter.sv
// moesif_bus_arbiter: combinational winner select, round-robin from pointer or fixed lowest-index
module moesif_bus_arbiter
    import moesif_bus_pkg::*;
#(
    parameter int NUMBER_OF_DEVICES = 4,
    parameter int INDEX_WIDTH       = $clog2(NUMBER_OF_DEVICES)
) (
    input  logic [NUMBER_OF_DEVICES-1:0] requests,
    input  logic [INDEX_WIDTH-1:0]       pointer,
    input  logic                         fixedPriority,
    output logic [NUMBER_OF_DEVICES-1:0] winnerOneHot,
    output logic [INDEX_WIDTH-1:0]       winnerIndex,
    output logic                         anyRequest
);

    logic [INDEX_WIDTH-1:0] candidate;
    logic                   found;

    always_comb begin
        winnerIndex = '0;
        candidate = '0;
        found = 1'b0;
        for (int i = 0; i < NUMBER_OF_DEVICES; i++) begin
            candidate = fixedPriority ? INDEX_WIDTH'(i)
                                      : INDEX_WIDTH'((int'(pointer) + i) % NUMBER_OF_DEVICES);
            if (!found && requests[candidate]) begin
                found = 1'b1;
                winnerIndex = candidate;
            end
        end
        winnerOneHot = found ? NUMBER_OF_DEVICES'(1) << winnerIndex : '0;
        anyRequest = found;
    end

endmodule

// File: rtl/moesif_coherence_bus_controller.sv
// moesif_coherence_bus_controller: sequenced arbitration, snoop accumulation, intervention and RAM access
module moesif_coherence_bus_controller
    import moesif_bus_pkg::*;
#(
    parameter int NUMBER_OF_DEVICES = 4,
    parameter int ADDRESS_WIDTH     = 16,
    parameter int DATA_WIDTH        = 16,
    parameter int SNOOP_WINDOW      = 2,
    parameter int ARBITRATION_MODE  = 0
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [NUMBER_OF_DEVICES-1:0]           requests,
    input  logic [2*NUMBER_OF_DEVICES-1:0]         commands,
    input  logic [NUMBER_OF_DEVICES*ADDRESS_WIDTH-1:0] addresses,
    input  logic [NUMBER_OF_DEVICES*DATA_WIDTH-1:0]    writeData,
    output logic [NUMBER_OF_DEVICES-1:0]           grants,
    output logic [NUMBER_OF_DEVICES-1:0]           done,
    output logic [DATA_WIDTH-1:0]                  readData,
    output logic                                   snoopValid,
    output logic [1:0]                             snoopCommand,
    output logic [ADDRESS_WIDTH-1:0]               snoopAddress,
    input  logic [NUMBER_OF_DEVICES-1:0]           sharedOuts,
    input  logic [NUMBER_OF_DEVICES-1:0]           ownedOuts,
    input  logic [NUMBER_OF_DEVICES*DATA_WIDTH-1:0]    ownerData,
    output logic                                   sharedIn,
    output logic                                   ownedIn,
    output logic                                   protocolError,
    output logic                                   ramRead,
    output logic                                   ramWrite,
    output logic [ADDRESS_WIDTH-1:0]               ramAddress,
    output logic [DATA_WIDTH-1:0]                  ramWriteData,
    input  logic [DATA_WIDTH-1:0]                  ramReadData,
    input  logic                                   ramFunctionComplete
);

    localparam int IW = $clog2(NUMBER_OF_DEVICES);
    localparam int CW = $clog2(SNOOP_WINDOW + 1);

    busStateType                  state;
    busCommandType                command;
    logic [IW-1:0]                pointer;
    logic [IW-1:0]                winner;
    logic [IW-1:0]                arbIndex;
    logic [IW-1:0]                ownerIndex;
    logic [IW-1:0]                lowOwner;
    logic [NUMBER_OF_DEVICES-1:0] arbOneHot;
    logic [NUMBER_OF_DEVICES-1:0] maskedShared;
    logic [NUMBER_OF_DEVICES-1:0] maskedOwned;
    logic [NUMBER_OF_DEVICES-1:0] ownedSeen;
    logic                         anyRequest;
    logic                         ownerFound;
    logic                         newOwner;
    logic                         hasOwner;
    logic                         lastSnoop;
    logic [CW-1:0]                snoopCount;
    logic [DATA_WIDTH-1:0]        ownerCapture;
    logic [DATA_WIDTH-1:0]        lowOwnerData;
    logic [DATA_WIDTH-1:0]        writeLatch;

    moesif_bus_arbiter #(
        .NUMBER_OF_DEVICES(NUMBER_OF_DEVICES),
        .INDEX_WIDTH(IW)
    ) arbiter (
        .requests(requests),
        .pointer(pointer),
        .fixedPriority(ARBITRATION_MODE == ARB_FIXED_PRIORITY),
        .winnerOneHot(arbOneHot),
        .winnerIndex(arbIndex),
        .anyRequest(anyRequest)
    );

    // The requester never snoops itself, so its own response bits are masked out.
    always_comb begin
        maskedShared = sharedOuts & ~grants;
        maskedOwned = ownedOuts & ~grants;
        lowOwner = '0;
        for (int i = NUMBER_OF_DEVICES - 1; i >= 0; i--)
            if (maskedOwned[i]) lowOwner = IW'(i);
        lowOwnerData = ownerData[lowOwner*DATA_WIDTH +: DATA_WIDTH];
        newOwner = |maskedOwned && (!ownerFound || lowOwner < ownerIndex);
        hasOwner = ownerFound || |maskedOwned;
        lastSnoop = snoopCount == CW'(SNOOP_WINDOW - 1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            command <= CMD_READ;
            pointer <= '0;
            winner <= '0;
            ownerIndex <= '0;
            ownerFound <= 1'b0;
            ownedSeen <= '0;
            snoopCount <= '0;
            ownerCapture <= '0;
            writeLatch <= '0;
            grants <= '0;
            done <= '0;
            readData <= '0;
            snoopValid <= 1'b0;
            snoopCommand <= '0;
            snoopAddress <= '0;
            sharedIn <= 1'b0;
            ownedIn <= 1'b0;
            protocolError <= 1'b0;
            ramRead <= 1'b0;
            ramWrite <= 1'b0;
            ramAddress <= '0;
            ramWriteData <= '0;
        end else begin
            case (state)
                IDLE: if (anyRequest) begin
                    grants <= arbOneHot;
                    winner <= arbIndex;
                    command <= busCommandType'(commands[arbIndex*2 +: 2]);
                    snoopCommand <= commands[arbIndex*2 +: 2];
                    snoopAddress <= addresses[arbIndex*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    writeLatch <= writeData[arbIndex*DATA_WIDTH +: DATA_WIDTH];
                    snoopValid <= 1'b1;
                    snoopCount <= '0;
                    ownerFound <= 1'b0;
                    ownedSeen <= '0;
                    state <= SNOOP;
                end
                SNOOP: begin
                    sharedIn <= sharedIn | (|maskedShared);
                    ownedIn <= ownedIn | (|maskedOwned);
                    ownedSeen <= ownedSeen | maskedOwned;
                    if ($countones(ownedSeen | maskedOwned) > 1) protocolError <= 1'b1;
                    if (newOwner) begin
                        ownerFound <= 1'b1;
                        ownerIndex <= lowOwner;
                        ownerCapture <= lowOwnerData;
                    end
                    snoopCount <= snoopCount + CW'(1);
                    if (lastSnoop) begin
                        snoopValid <= 1'b0;
                        if (command == CMD_WRITEBACK) begin
                            ramWrite <= 1'b1;
                            ramAddress <= snoopAddress;
                            ramWriteData <= writeLatch;
                            state <= RAM_WRITE;
                        end else if (command == CMD_INVALIDATE) begin
                            done <= grants;
                            state <= COMPLETE;
                        end else if (hasOwner) begin
                            state <= INTERVENE;
                        end else begin
                            ramRead <= 1'b1;
                            ramAddress <= snoopAddress;
                            state <= RAM_READ;
                        end
                    end
                end
                INTERVENE: begin
                    readData <= ownerCapture;
                    done <= grants;
                    state <= COMPLETE;
                end
                RAM_READ: if (ramFunctionComplete) begin
                    ramRead <= 1'b0;
                    readData <= ramReadData;
                    done <= grants;
                    state <= COMPLETE;
                end
                RAM_WRITE: if (ramFunctionComplete) begin
                    ramWrite <= 1'b0;
                    done <= grants;
                    state <= COMPLETE;
                end
                COMPLETE: begin
                    done <= '0;
                    grants <= '0;
                    sharedIn <= 1'b0;
                    ownedIn <= 1'b0;
                    pointer <= (winner == IW'(NUMBER_OF_DEVICES - 1)) ? '0 : winner + IW'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_moesif_coherence_bus_controller.sv
// tb_moesif_coherence_bus_controller: directed and randomized transactions against a transaction-level model
module tb_moesif_coherence_bus_controller;
    import moesif_bus_pkg::*;

    localparam int N = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int W = 2;

    logic clock = 1'b0;
    logic reset;
    logic [N-1:0] requests, grants, done, sharedOuts, ownedOuts;
    logic [2*N-1:0] commands;
    logic [N*AW-1:0] addresses;
    logic [N*DW-1:0] writeData, ownerData;
    logic [DW-1:0] readData, ramWriteData, ramReadData;
    logic [AW-1:0] snoopAddress, ramAddress;
    logic [1:0] snoopCommand;
    logic snoopValid, sharedIn, ownedIn, protocolError, ramRead, ramWrite, ramFunctionComplete;

    logic [1:0] cmdA[N];
    logic [AW-1:0] addrA[N];
    logic [DW-1:0] wdA[N];
    logic [DW-1:0] odA[N];
    logic [1:0] ptr;
    bit expErr;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < N; g++) begin : pack
        assign commands[2*g +: 2] = cmdA[g];
        assign addresses[g*AW +: AW] = addrA[g];
        assign writeData[g*DW +: DW] = wdA[g];
        assign ownerData[g*DW +: DW] = odA[g];
    end

    moesif_coherence_bus_controller #(
        .NUMBER_OF_DEVICES(N),
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW),
        .SNOOP_WINDOW(W),
        .ARBITRATION_MODE(0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .requests(requests),
        .commands(commands),
        .addresses(addresses),
        .writeData(writeData),
        .grants(grants),
        .done(done),
        .readData(readData),
        .snoopValid(snoopValid),
        .snoopCommand(snoopCommand),
        .snoopAddress(snoopAddress),
        .sharedOuts(sharedOuts),
        .ownedOuts(ownedOuts),
        .ownerData(ownerData),
        .sharedIn(sharedIn),
        .ownedIn(ownedIn),
        .protocolError(protocolError),
        .ramRead(ramRead),
        .ramWrite(ramWrite),
        .ramAddress(ramAddress),
        .ramWriteData(ramWriteData),
        .ramReadData(ramReadData),
        .ramFunctionComplete(ramFunctionComplete)
    );

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One whole bus transaction; caller is at a negedge with the DUT idle.
    task automatic runTxn(input logic [3:0] req, input logic [3:0] sh, input logic [3:0] ow,
                          input int lat, input bit scramble);
        logic [1:0] win, low, c;
        logic [3:0] oh, mo;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expWd, ramVal;
        bit found, isRead, intervene, finished;
        int n, sv, rr, rw, expLat;
        found = 0;
        win = 0;
        for (int j = 0; j < N; j++)
            if (!found && req[ptr + 2'(j)]) begin
                found = 1;
                win = ptr + 2'(j);
            end
        oh = 4'b0001 << win;
        c = cmdA[win];
        expAddr = addrA[win];
        expWd = wdA[win];
        mo = ow & ~oh;
        low = 0;
        for (int j = N - 1; j >= 0; j--)
            if (mo[2'(j)]) low = 2'(j);
        if ($countones(mo) > 1) expErr = 1;
        isRead = c == CMD_READ || c == CMD_READ_EXCLUSIVE;
        intervene = isRead && mo != 0;
        expLat = (c == CMD_INVALIDATE) ? W + 1 : intervene ? W + 2 : W + 1 + lat;
        ramVal = 0;
        requests = req;
        sharedOuts = sh;
        ownedOuts = ow;
        n = 0; sv = 0; rr = 0; rw = 0; finished = 0;
        while (!finished && n < 100) begin
            @(posedge clock);
            @(negedge clock);
            n++;
            ramFunctionComplete = 0;
            if (n == 1) begin
                checkValue("grant", 32'(grants), 32'(oh));
                checkValue("snoopAddress", 32'(snoopAddress), 32'(expAddr));
                checkValue("snoopCommand", 32'(snoopCommand), 32'(c));
                if (scramble) begin
                    requests = 0;
                    cmdA[win] = ~c;
                    addrA[win] = ~expAddr;
                    wdA[win] = ~expWd;
                end
            end
            if (snoopValid) sv++;
            if (ramRead) rr++;
            if (ramWrite) rw++;
            if (ramRead || ramWrite) begin
                checkValue("ramAddress", 32'(ramAddress), 32'(expAddr));
                if (ramWrite) checkValue("ramWriteData", 32'(ramWriteData), 32'(expWd));
                if (rr + rw == lat) begin
                    ramVal = 16'($urandom);
                    ramReadData = ramVal;
                    ramFunctionComplete = 1;
                end
            end
            if (done != 0) begin
                finished = 1;
                checkValue("done", 32'(done), 32'(oh));
                checkValue("latency", 32'(n), 32'(expLat));
                checkValue("snoopCycles", 32'(sv), 32'(W));
                checkValue("sharedIn", 32'(sharedIn), 32'(|(sh & ~oh)));
                checkValue("ownedIn", 32'(ownedIn), 32'(mo != 0));
                checkValue("protocolError", 32'(protocolError), 32'(expErr));
                checkValue("ramReadCycles", 32'(rr), 32'((isRead && !intervene) ? lat : 0));
                checkValue("ramWriteCycles", 32'(rw), 32'((c == CMD_WRITEBACK) ? lat : 0));
                if (isRead) checkValue("readData", 32'(readData), 32'(intervene ? odA[low] : ramVal));
            end
        end
        ramFunctionComplete = 0;
        if (!finished) checkValue("doneTimeout", 0, 1);
        @(posedge clock);
        @(negedge clock);
        checkValue("doneClear", 32'(done), 0);
        checkValue("grantClear", 32'(grants), 0);
        checkValue("sharedClear", 32'({sharedIn, ownedIn}), 0);
        requests = 0;
        ptr = win + 2'd1;
    endtask

    initial begin
        reset = 1;
        requests = 0;
        sharedOuts = 0;
        ownedOuts = 0;
        ramReadData = 0;
        ramFunctionComplete = 0;
        for (int d = 0; d < N; d++) begin
            cmdA[d] = CMD_INVALIDATE;
            addrA[d] = 16'(d * 16);
            wdA[d] = 0;
            odA[d] = 0;
        end
        ptr = 0;
        expErr = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkValue("resetGrants", 32'({grants, done}), 0);
        checkValue("resetStrobes", 32'({snoopValid, ramRead, ramWrite, protocolError, sharedIn, ownedIn}), 0);
        checkValue("resetReadData", 32'(readData), 0);
        reset = 0;

        repeat (3) runTxn(4'b1010, 4'b0000, 4'b0000, 1, 0);

        cmdA[0] = CMD_READ; addrA[0] = 16'h0040; odA[2] = 16'hBEEF;
        runTxn(4'b0001, 4'b0000, 4'b0100, 1, 0);

        // Abort a RAM read with reset; the pointer must restart at device 0.
        addrA[0] = 16'h0100;
        requests = 4'b0001;
        sharedOuts = 0;
        ownedOuts = 0;
        for (int i = 0; i < 20 && !ramRead; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
        checkValue("ramReadBeforeReset", 32'(ramRead), 1);
        reset = 1;
        requests = 0;
        @(posedge clock);
        @(negedge clock);
        checkValue("resetRamRead", 32'({ramRead, ramWrite}), 0);
        checkValue("resetMidGrants", 32'({grants, done, snoopValid}), 0);
        reset = 0;
        ptr = 0;
        expErr = 0;
        cmdA[0] = CMD_INVALIDATE; cmdA[2] = CMD_INVALIDATE;
        runTxn(4'b0101, 4'b0000, 4'b0000, 1, 0);

        cmdA[0] = CMD_READ; addrA[0] = 16'h0100;
        runTxn(4'b0001, 4'b0010, 4'b0000, 3, 0);

        cmdA[3] = CMD_WRITEBACK; addrA[3] = 16'h0200; wdA[3] = 16'hCAFE;
        runTxn(4'b1000, 4'b0000, 4'b0000, 2, 0);

        cmdA[0] = CMD_READ; odA[1] = 16'h1111; odA[2] = 16'h2222;
        runTxn(4'b0001, 4'b0000, 4'b0110, 1, 0);

        for (int t = 0; t < 60; t++) begin
            for (int d = 0; d < N; d++) begin
                cmdA[d] = 2'($urandom);
                addrA[d] = 16'($urandom);
                wdA[d] = 16'($urandom);
                odA[d] = 16'($urandom);
            end
            runTxn(4'($urandom_range(1, 15)), 4'($urandom), 4'($urandom) & 4'($urandom),
                   $urandom_range(1, 4), $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
